// File: rtl/toast_muldiv_if.sv
// Handshake and operand bundle between the execute stage and the RV32M multiply/divide unit.
interface toast_muldiv_if;
  logic        start_i;
  logic [2:0]  md_op_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        kill_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output start_i, md_op_i, op1_i, op2_i, kill_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, md_op_i, op1_i, op2_i, kill_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/toast_muldiv.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on operand magnitudes,
// sign fix-up in FIN, result registered on the FIN -> IDLE edge.
//
// state  | meaning
// S_IDLE | waiting for start_i; operands latched on accept
// S_CALC | 32 iterations of the shared 33-bit add/subtract datapath
// S_FIN  | sign correction and special-case override, result written on exit
module toast_muldiv (
  input  logic          clk_i,
  input  logic          rst_i,
  toast_muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic        r_neg1, r_neg2, r_div0, r_ovf, r_done;
  logic [31:0] r_acc, r_lo, r_b, r_result;

  logic        w_accept, w_in_div, w_sgn1, w_sgn2, w_neg1, w_neg2, w_is_div;
  logic [31:0] w_mag1, w_mag2, w_quot, w_rem, w_fin;
  logic [32:0] w_shift, w_opa, w_opb, w_sum;
  logic [63:0] w_prod, w_prod_fix;

  assign w_accept = bus.start_i & ~bus.kill_i;
  assign w_in_div = bus.md_op_i[2];
  assign w_sgn1   = w_in_div ? ~bus.md_op_i[0]
                             : (bus.md_op_i[1:0] == 2'b01) | (bus.md_op_i[1:0] == 2'b10);
  assign w_sgn2   = w_in_div ? ~bus.md_op_i[0] : (bus.md_op_i[1:0] == 2'b01);
  assign w_neg1   = w_sgn1 & bus.op1_i[31];
  assign w_neg2   = w_sgn2 & bus.op2_i[31];
  assign w_mag1   = w_neg1 ? (32'd0 - bus.op1_i) : bus.op1_i;
  assign w_mag2   = w_neg2 ? (32'd0 - bus.op2_i) : bus.op2_i;

  // Shared adder: multiply adds the multiplicand, divide subtracts the divisor from the shifted remainder
  assign w_is_div = r_op[2];
  assign w_shift  = {r_acc, r_lo[31]};
  assign w_opa    = w_is_div ? w_shift : {1'b0, r_acc};
  assign w_opb    = w_is_div ? ~{1'b0, r_b} : (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_sum    = w_opa + w_opb + {32'd0, w_is_div};

  assign w_prod     = {r_acc, r_lo};
  assign w_prod_fix = (r_neg1 ^ r_neg2) ? (64'd0 - w_prod) : w_prod;
  assign w_quot     = r_div0 ? 32'hFFFF_FFFF :
                      r_ovf  ? 32'h8000_0000 :
                      ((r_neg1 ^ r_neg2) ? (32'd0 - r_lo) : r_lo);
  assign w_rem      = r_ovf ? 32'd0 : (r_neg1 ? (32'd0 - r_acc) : r_acc);
  assign w_fin      = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                              : ((r_op[1:0] == 2'b00) ? w_prod_fix[31:0] : w_prod_fix[63:32]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
      S_CALC:  if (bus.kill_i) w_state_nxt = S_IDLE;
               else if (r_cnt == 5'd31) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_op     <= 3'd0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_acc    <= 32'd0;
      r_lo     <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= bus.md_op_i;
          r_neg1 <= w_neg1;
          r_neg2 <= w_neg2;
          r_acc  <= 32'd0;
          r_lo   <= w_in_div ? w_mag1 : w_mag2;
          r_b    <= w_in_div ? w_mag2 : w_mag1;
          r_cnt  <= 5'd0;
          r_div0 <= w_in_div & (bus.op2_i == 32'd0);
          r_ovf  <= w_in_div & ~bus.md_op_i[0] & (bus.op1_i == 32'h8000_0000)
                    & (bus.op2_i == 32'hFFFF_FFFF);
        end
        S_CALC: if (!bus.kill_i) begin
          r_cnt <= r_cnt + 5'd1;
          if (w_is_div) begin
            // Borrow out of the trial subtract means restore the shifted remainder
            r_acc <= w_sum[32] ? w_shift[31:0] : w_sum[31:0];
            r_lo  <= {r_lo[30:0], ~w_sum[32]};
          end else begin
            r_acc <= w_sum[32:1];
            r_lo  <= {w_sum[0], r_lo[31:1]};
          end
        end
        S_FIN: if (!bus.kill_i) begin
          r_result <= w_fin;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = (r_state != S_IDLE);
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_toast_muldiv.sv
// Directed and randomized bench for toast_muldiv against an arithmetic reference model.
module tb_toast_muldiv;
  logic clk = 1'b0;
  logic rst;
  toast_muldiv_if bus();

  toast_muldiv dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic        cmp_en = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_pend = 32'd0;
  logic        m_done = 1'b0;
  logic [31:0] last_res = 32'd0;
  logic [31:0] corner [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0] ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sub = {32'd0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * sub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Timing model: 33 edges from accept to done, kill or reset drop the pending result
  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_done = 1'b0; m_res = 32'd0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (bus.kill_i) m_rem = 0;
        else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_res = m_pend; m_done = 1'b1; end
        end
      end else if (bus.start_i && !bus.kill_i) begin
        m_rem  = 33;
        m_pend = golden(bus.md_op_i, bus.op1_i, bus.op2_i);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(bus.busy_o), 32'(m_rem > 0));
      chk("done", 32'(bus.done_o), 32'(m_done));
      chk("result", bus.result_o, m_res);
    end
  end

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.md_op_i = op; bus.op1_i = a; bus.op2_i = b; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.op1_i = $urandom; bus.op2_i = $urandom; bus.md_op_i = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done_o && n < 100) begin @(negedge clk); n++; end
    chk("done_timeout", 32'(bus.done_o), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
    int n;
    launch(op, a, b);
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'd33);
    chk(nm, bus.result_o, exp);
    last_res = exp;
  endtask

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return corner[r];
    return $urandom;
  endfunction

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.start_i = 1'b0; bus.kill_i = 1'b0; bus.md_op_i = 3'd0;
    bus.op1_i = 32'd0; bus.op2_i = 32'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
    run_op(3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "div0");
    run_op(3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu0");
    run_op(3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678, "rem0");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem0_neg");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");

    // Kill sampled at E+10
    launch(3'd5, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    chk("kill_busy", 32'(bus.busy_o), 32'd0);
    chk("kill_res", bus.result_o, last_res);
    @(negedge clk);
    run_op(3'd0, 32'd3, 32'd5, 32'd15, "mul_after_kill");

    // Start during CALC is ignored; start in the done cycle is taken back-to-back
    launch(3'd5, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    bus.md_op_i = 3'd0; bus.op1_i = 32'd9; bus.op2_i = 32'd9; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done(n);
    chk("ignored_lat", 32'(n + 5), 32'd33);
    chk("ignored_res", bus.result_o, 32'd333);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "b2b");

    // Kill together with start in IDLE drops the start
    bus.start_i = 1'b1; bus.kill_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.kill_i = 1'b0;
    chk("kill_start_busy", 32'(bus.busy_o), 32'd0);

    // Kill in FIN discards the result
    launch(3'd0, 32'd6, 32'd7);
    repeat (32) @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    chk("kill_fin_done", 32'(bus.done_o), 32'd0);
    chk("kill_fin_res", bus.result_o, 32'd2);
    @(negedge clk);

    // Reset mid-CALC
    launch(3'd0, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_rst_done", 32'(bus.done_o), 32'd0);
    chk("mid_rst_res", bus.result_o, 32'd0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 48; i++) begin
      op = 3'(i % 8);
      a  = pick();
      b  = pick();
      run_op(op, a, b, golden(op, a, b), "rand");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
